// File: rtl/regfile_operand_seq.sv
// regfile_operand_seq: reads two operands from a single-port regfile, hands them to the ALU, writes the result back.
// Define SEQ_TIMEOUT_EN to add an EXEC watchdog that aborts with err after TIMEOUT cycles without res_valid.
module regfile_operand_seq #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] src_a,
    input  logic [A_WIDTH-1:0] src_b,
    input  logic [A_WIDTH-1:0] dst,
    output logic               busy,
    output logic [D_WIDTH-1:0] op_a,
    output logic [D_WIDTH-1:0] op_b,
    output logic               op_valid,
    input  logic               res_valid,
    input  logic [D_WIDTH-1:0] res_data,
    output logic               done,
    output logic               err,
    output logic               rf_en,
    output logic               rf_rw,
    output logic [A_WIDTH-1:0] rf_addr,
    output logic [D_WIDTH-1:0] rf_wdata,
    input  logic [D_WIDTH-1:0] rf_rdata
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, EXEC, WB} state_t;
    state_t state, state_nxt;
    logic [A_WIDTH-1:0] src_b_q, dst_q, src_b_nxt, dst_nxt, rf_addr_nxt;
    logic [D_WIDTH-1:0] op_a_nxt, op_b_nxt, rf_wdata_nxt;
    logic op_valid_nxt, done_nxt, err_nxt, rf_en_nxt, rf_rw_nxt, timeout;

    assign busy = state != IDLE;

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    // cnt holds the number of EXEC cycles already spent without a result
    assign timeout = state == EXEC && !res_valid && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge Clk)
        if (Rst || state != EXEC) cnt <= '0;
        else if (!res_valid) cnt <= cnt + 1'b1;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            src_b_q  <= '0;
            dst_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rf_en    <= 1'b0;
            rf_rw    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else begin
            state    <= state_nxt;
            src_b_q  <= src_b_nxt;
            dst_q    <= dst_nxt;
            op_a     <= op_a_nxt;
            op_b     <= op_b_nxt;
            op_valid <= op_valid_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            rf_en    <= rf_en_nxt;
            rf_rw    <= rf_rw_nxt;
            rf_addr  <= rf_addr_nxt;
            rf_wdata <= rf_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RD_A : IDLE;
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = CAP_B;
            CAP_B:   state_nxt = EXEC;
            EXEC:    state_nxt = res_valid ? WB : timeout ? IDLE : EXEC;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src_b_nxt    = src_b_q;
        dst_nxt      = dst_q;
        op_a_nxt     = op_a;
        op_b_nxt     = op_b;
        op_valid_nxt = op_valid;
        rf_en_nxt    = rf_en;
        rf_rw_nxt    = rf_rw;
        rf_addr_nxt  = rf_addr;
        rf_wdata_nxt = rf_wdata;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            IDLE: if (start) begin
                src_b_nxt   = src_b;
                dst_nxt     = dst;
                rf_en_nxt   = 1'b1;
                rf_rw_nxt   = 1'b0;
                rf_addr_nxt = src_a;
            end
            RD_A: rf_addr_nxt = src_b_q;
            RD_B: begin
                op_a_nxt  = rf_rdata;
                rf_en_nxt = 1'b0;
            end
            CAP_B: begin
                op_b_nxt     = rf_rdata;
                op_valid_nxt = 1'b1;
            end
            EXEC: if (res_valid) begin
                op_valid_nxt = 1'b0;
                rf_en_nxt    = 1'b1;
                rf_rw_nxt    = 1'b1;
                rf_addr_nxt  = dst_q;
                rf_wdata_nxt = res_data;
            end else if (timeout) begin
                op_valid_nxt = 1'b0;
                err_nxt      = 1'b1;
            end
            WB: begin
                rf_en_nxt    = 1'b0;
                rf_rw_nxt    = 1'b0;
                rf_wdata_nxt = '0;
                done_nxt     = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_regfile_operand_seq.sv
// tb_regfile_operand_seq: directed bench with a behavioural single-port regfile; define SEQ_TIMEOUT_EN for watchdog steps.
module tb_regfile_operand_seq;
    logic        Clk = 1'b0;
    logic        Rst, start, res_valid;
    logic [4:0]  src_a, src_b, dst;
    logic        busy, op_valid, done, err, rf_en, rf_rw;
    logic [31:0] op_a, op_b, res_data, rf_wdata, rf_rdata;
    logic [4:0]  rf_addr;
    logic [31:0] mem [32];
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;
    int          passed = 0, total = 0;

    always #5 Clk = ~Clk;

    regfile_operand_seq dut (
        .Clk(Clk), .Rst(Rst), .start(start), .src_a(src_a), .src_b(src_b), .dst(dst),
        .busy(busy), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
        .res_valid(res_valid), .res_data(res_data), .done(done), .err(err),
        .rf_en(rf_en), .rf_rw(rf_rw), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // regfile: write on En&RW, registered read data, 0 when no read was issued
    always @(posedge Clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (rf_en && rf_rw) mem[rf_addr] <= rf_wdata;
        rf_rdata <= (rf_en && !rf_rw) ? mem[rf_addr] : 32'h0;
    end

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step;
        pre_we = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        start = 1'b1; src_a = a; src_b = b; dst = d;
        step;
        start = 1'b0; src_a = '0; src_b = '0; dst = '0;
    endtask

    initial begin
        Rst = 1'b1; start = 1'b0; src_a = '0; src_b = '0; dst = '0;
        res_valid = 1'b0; res_data = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 32; i++) preload(5'(i), 32'h0);
        preload(5'd3, 32'h11);
        preload(5'd7, 32'h22);
        preload(5'd5, 32'h7);
        chk("rst_busy", busy, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rf_en", rf_en, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        Rst = 1'b0;
        // command 1: R9 = R3 + R7
        issue(5'd3, 5'd7, 5'd9);
        chk("rda_busy", busy, 1);
        chk("rda_en", rf_en, 1);
        chk("rda_rw", rf_rw, 0);
        chk("rda_addr", rf_addr, 3);
        step;
        chk("rdb_addr", rf_addr, 7);
        start = 1'b1; src_a = 5'd1; src_b = 5'd1; dst = 5'd1;
        step;
        chk("capb_op_a", op_a, 32'h11);
        chk("capb_en", rf_en, 0);
        chk("capb_op_valid", op_valid, 0);
        step;
        chk("exec_op_valid", op_valid, 1);
        chk("exec_op_b", op_b, 32'h22);
        start = 1'b0; src_a = '0; src_b = '0; dst = '0;
        step;
        chk("exec_hold_valid", op_valid, 1);
        chk("exec_hold_a", op_a, 32'h11);
        step;
        res_valid = 1'b1; res_data = 32'h33;
        step;
        res_valid = 1'b0; res_data = '0;
        chk("wb_en", rf_en, 1);
        chk("wb_rw", rf_rw, 1);
        chk("wb_addr", rf_addr, 9);
        chk("wb_wdata", rf_wdata, 32'h33);
        chk("wb_op_valid", op_valid, 0);
        step;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_wdata", rf_wdata, 0);
        chk("done_err", err, 0);
        chk("r9_written", mem[9], 32'h33);
        chk("r1_untouched", mem[1], 0);
        // back-to-back on the done cycle, reading the just-written R9
        issue(5'd9, 5'd7, 5'd10);
        chk("b2b_done_low", done, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_addr", rf_addr, 9);
        step;
        step;
        chk("b2b_raw_op_a", op_a, 32'h33);
        step;
        chk("b2b_exec", op_valid, 1);
        // reset in EXEC drops the pending write-back
        Rst = 1'b1; res_valid = 1'b1; res_data = 32'hdead;
        step;
        Rst = 1'b0; res_valid = 1'b0; res_data = '0;
        chk("rst_exec_busy", busy, 0);
        chk("rst_exec_valid", op_valid, 0);
        chk("rst_exec_op_a", op_a, 0);
        step;
        step;
        chk("rst_r10_kept", mem[10], 0);
        // result strobe while idle is ignored
        res_valid = 1'b1; res_data = 32'h5;
        step;
        res_valid = 1'b0; res_data = '0;
        chk("idle_res_busy", busy, 0);
        chk("idle_res_en", rf_en, 0);
        // same register for both sources and destination
        issue(5'd5, 5'd5, 5'd5);
        step;
        step;
        step;
        chk("same_op_a", op_a, 32'h7);
        chk("same_op_b", op_b, 32'h7);
        chk("same_valid", op_valid, 1);
        res_valid = 1'b1; res_data = 32'hE;
        step;
        res_valid = 1'b0; res_data = '0;
        chk("same_wb_addr", rf_addr, 5);
        chk("same_wb_wdata", rf_wdata, 32'hE);
        step;
        chk("same_done", done, 1);
        chk("r5_written", mem[5], 32'hE);
`ifdef SEQ_TIMEOUT_EN
        // no result: abort after 16 EXEC cycles
        issue(5'd3, 5'd7, 5'd11);
        step;
        step;
        step;
        for (int i = 0; i < 15; i++) step;
        chk("to_still_exec", op_valid, 1);
        chk("to_no_err_yet", err, 0);
        step;
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_valid", op_valid, 0);
        chk("to_no_write", rf_en, 0);
        step;
        chk("to_err_pulse", err, 0);
        chk("to_r11_kept", mem[11], 0);
        // result on the 16th cycle wins
        issue(5'd3, 5'd7, 5'd12);
        step;
        step;
        step;
        for (int i = 0; i < 15; i++) step;
        res_valid = 1'b1; res_data = 32'h55;
        step;
        res_valid = 1'b0; res_data = '0;
        chk("late_wb_wdata", rf_wdata, 32'h55);
        chk("late_no_err", err, 0);
        step;
        chk("late_done", done, 1);
        chk("late_err", err, 0);
        chk("r12_written", mem[12], 32'h55);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
